// File: rtl/oled_frame_streamer_if.sv
// ---------------------------------------------------------------------------
// oled_frame_streamer_if
//
// Purpose: bundles the two buses the frame streamer talks to.
//   Display buffer read port : buf_addr, buf_rd_en (streamer -> buffer),
//                              buf_rdata (buffer -> streamer, valid one
//                              cycle after buf_rd_en).
//   SPI master byte port     : spi_data, spi_start, dc (streamer -> SPI),
//                              spi_done (SPI -> streamer).
//
// Handshake: spi_start is a one-cycle pulse that launches spi_data; the
// streamer holds spi_data and dc unchanged until the SPI master answers with
// a one-cycle spi_done, and only then may the next spi_start follow. Exactly
// one spi_done is expected per spi_start.
//
// Modports:
//   master - the frame streamer side
//   slave  - the buffer RAM / SPI master side (or a testbench model)
// ---------------------------------------------------------------------------
interface oled_frame_streamer_if;
    logic [9:0] buf_addr;
    logic       buf_rd_en;
    logic [7:0] buf_rdata;
    logic [7:0] spi_data;
    logic       spi_start;
    logic       spi_done;
    logic       dc;

    modport master (
        output buf_addr,
        output buf_rd_en,
        input  buf_rdata,
        output spi_data,
        output spi_start,
        input  spi_done,
        output dc
    );

    modport slave (
        input  buf_addr,
        input  buf_rd_en,
        output buf_rdata,
        input  spi_data,
        input  spi_start,
        output spi_done,
        input  dc
    );
endinterface

// File: rtl/oled_frame_streamer.sv
// ---------------------------------------------------------------------------
// oled_frame_streamer
//
// Purpose: on a frame request, sends the SSD1331 column/row address window
// commands (dc=0) and then streams the 1-bpp display buffer as RGB565 pixel
// data (dc=1, high byte first), one byte per SPI start/done handshake.
//
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   init_done   - OLED init complete; frame requests are accepted only when high
//   frame_req   - one-cycle request for a full frame transfer
//   bus         - buffer read port + SPI byte port (see oled_frame_streamer_if)
//   frame_busy  - high from the accepted request until frame_done
//   frame_done  - one-cycle pulse after the last pixel byte completes
//   dbg_state   - current FSM state, for debug and assertion binding
// ---------------------------------------------------------------------------
module oled_frame_streamer #(
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    parameter int          WIDTH    = 96,
    parameter int          HEIGHT   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init_done,
    input  logic                         frame_req,
    oled_frame_streamer_if.master        bus,
    output logic                         frame_busy,
    output logic                         frame_done,
    output logic [3:0]                   dbg_state
);

    localparam logic [9:0] LAST_ADDR = 10'(WIDTH * HEIGHT / 8 - 1);
    localparam logic [2:0] LAST_CMD  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD_SEND,
        S_CMD_WAIT,
        S_FETCH,
        S_FETCH_WAIT,
        S_PIX_HI,
        S_PIX_HI_WAIT,
        S_PIX_LO,
        S_PIX_LO_WAIT,
        S_DONE
    } state_t;

    // Address window: full-screen column range then full-screen row range.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h15;
            3'd1:    return 8'h00;
            3'd2:    return 8'(WIDTH - 1);
            3'd3:    return 8'h75;
            3'd4:    return 8'h00;
            3'd5:    return 8'(HEIGHT - 1);
            default: return 8'h00;
        endcase
    endfunction

    state_t      state_q,     state_d;
    logic [2:0]  cmd_idx_q,   cmd_idx_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  pix_q,       pix_d;
    logic [9:0]  addr_q,      addr_d;
    logic [7:0]  spi_data_q,  spi_data_d;
    logic        spi_start_q, spi_start_d;
    logic        dc_q,        dc_d;
    logic        rd_en_q,     rd_en_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [15:0] color;

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        cmd_idx_d = cmd_idx_q;
        bit_idx_d = bit_idx_q;
        pix_d     = pix_q;
        addr_d    = addr_q;

        case (state_q)
            S_IDLE: begin
                if (frame_req && init_done) begin
                    state_d   = S_CMD_SEND;
                    cmd_idx_d = 3'd0;
                    bit_idx_d = 3'd0;
                    addr_d    = 10'd0;
                end
            end
            S_CMD_SEND: state_d = S_CMD_WAIT;
            S_CMD_WAIT: begin
                if (bus.spi_done) begin
                    if (cmd_idx_q == LAST_CMD) begin
                        state_d = S_FETCH;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 3'd1;
                        state_d   = S_CMD_SEND;
                    end
                end
            end
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                // buf_rdata belongs to the read issued in S_FETCH.
                pix_d     = bus.buf_rdata;
                bit_idx_d = 3'd0;
                state_d   = S_PIX_HI;
            end
            S_PIX_HI: state_d = S_PIX_HI_WAIT;
            S_PIX_HI_WAIT: begin
                if (bus.spi_done) state_d = S_PIX_LO;
            end
            S_PIX_LO: state_d = S_PIX_LO_WAIT;
            S_PIX_LO_WAIT: begin
                if (bus.spi_done) begin
                    if (bit_idx_q != 3'd7) begin
                        // LSB is the leftmost pixel, so shift right to advance.
                        bit_idx_d = bit_idx_q + 3'd1;
                        pix_d     = {1'b0, pix_q[7:1]};
                        state_d   = S_PIX_HI;
                    end else if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + 10'd1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic, decoded from the next state so every output is a flop
    // that lines up with the state it belongs to.
    always_comb begin
        color       = pix_d[0] ? FG_COLOR : BG_COLOR;
        spi_start_d = (state_d == S_CMD_SEND) || (state_d == S_PIX_HI) ||
                      (state_d == S_PIX_LO);
        spi_data_d  = spi_data_q;
        case (state_d)
            S_CMD_SEND: spi_data_d = cmd_byte(cmd_idx_d);
            S_PIX_HI:   spi_data_d = color[15:8];
            S_PIX_LO:   spi_data_d = color[7:0];
            default:    spi_data_d = spi_data_q;
        endcase
        // dc rises when the first fetch starts (after the last command's
        // done) and falls in DONE, so it never moves under a byte in flight.
        dc_d    = (state_d == S_FETCH)    || (state_d == S_FETCH_WAIT) ||
                  (state_d == S_PIX_HI)   || (state_d == S_PIX_HI_WAIT) ||
                  (state_d == S_PIX_LO)   || (state_d == S_PIX_LO_WAIT);
        rd_en_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_idx_q   <= 3'd0;
            bit_idx_q   <= 3'd0;
            pix_q       <= 8'h00;
            addr_q      <= 10'd0;
            spi_data_q  <= 8'h00;
            spi_start_q <= 1'b0;
            dc_q        <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_idx_q   <= cmd_idx_d;
            bit_idx_q   <= bit_idx_d;
            pix_q       <= pix_d;
            addr_q      <= addr_d;
            spi_data_q  <= spi_data_d;
            spi_start_q <= spi_start_d;
            dc_q        <= dc_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.buf_addr  = addr_q;
    assign bus.buf_rd_en = rd_en_q;
    assign bus.spi_data  = spi_data_q;
    assign bus.spi_start = spi_start_q;
    assign bus.dc        = dc_q;
    assign frame_busy    = busy_q;
    assign frame_done    = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_oled_frame_streamer
//
// Drives the streamer with a behavioural display-buffer RAM and an SPI master
// that answers each spi_start with a spi_done after a random delay. The
// expected byte stream for a frame is produced from the buffer contents by
// walking pixels in raster order. A reduced 24x4 geometry keeps frames short
// while still giving several buffer bytes per row.
// ---------------------------------------------------------------------------
module tb_oled_frame_streamer;

  localparam int W       = 24;
  localparam int H       = 4;
  localparam int NBYTES  = W * H / 8;
  localparam int NTOTAL  = 6 + W * H * 2;
  localparam int TIMEOUT = NTOTAL * 46 + NBYTES * 4 + 200;
  localparam logic [15:0] FG = 16'hF800;
  localparam logic [15:0] BG = 16'h001F;

  typedef struct {
    logic [7:0]  fill;
    logic [7:0]  first;
    logic [7:0]  last;
    int          dmin;
    int          dmax;
    int          exp_fg;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       init_done;
  logic       frame_req;
  logic       frame_busy;
  logic       frame_done;
  logic [3:0] dbg_state;

  oled_frame_streamer_if bus ();

  oled_frame_streamer #(
    .FG_COLOR(FG),
    .BG_COLOR(BG),
    .WIDTH   (W),
    .HEIGHT  (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .frame_req (frame_req),
    .bus       (bus),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .dbg_state (dbg_state)
  );

  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mem [NBYTES];
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  int         byte_idx = 0;
  int         rd_next  = 0;
  int         rd_cnt   = 0;
  int         done_cnt = 0;
  int         dmin     = 1;
  int         dmax     = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference stream: window commands, then every pixel in raster order.
  function automatic void build_expected();
    logic [7:0]  b;
    logic [15:0] c;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h15});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'(W - 1)});
    exp_q.push_back({1'b0, 8'h75});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'(H - 1)});
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        b = mem[y * (W / 8) + x / 8];
        c = b[3'(x % 8)] ? FG : BG;
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
    end
  endfunction

  // ---------------- SPI master model ----------------
  initial begin : spi_model
    bit         pending;
    bit         unstable;
    int         cnt;
    logic [8:0] held;
    logic [8:0] got;
    pending = 1'b0;
    unstable = 1'b0;
    cnt = 0;
    held = '0;
    bus.spi_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.spi_done = 1'b0;
      if (reset) begin
        pending = 1'b0;
      end else if (bus.spi_start) begin
        check("no_start_in_flight", 32'(pending), 32'd0);
        got = {bus.dc, bus.spi_data};
        if (byte_idx < NTOTAL && exp_q.size() > 0)
          check($sformatf("byte%0d", byte_idx), 32'(got), 32'(exp_q.pop_front()));
        else
          check("bytes_in_frame", 32'(byte_idx + 1), 32'(NTOTAL));
        cap_q.push_back(got);
        byte_idx++;
        held     = got;
        unstable = 1'b0;
        pending  = 1'b1;
        cnt      = int'($urandom_range(dmax, dmin));
      end else if (pending) begin
        if ({bus.dc, bus.spi_data} !== held) unstable = 1'b1;
        cnt--;
        if (cnt <= 0) begin
          bus.spi_done = 1'b1;
          pending = 1'b0;
          check("byte_held_stable", 32'(unstable), 32'd0);
        end
      end
    end
  end

  // ---------------- display buffer model ----------------
  // Data appears after the read strobe, survives the capture edge, then is
  // replaced by junk so a late capture is visible.
  initial begin : buf_model
    int age;
    age = 2;
    bus.buf_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && bus.buf_rd_en) begin
        check($sformatf("rd_addr%0d", rd_cnt), 32'(bus.buf_addr), 32'(rd_next));
        bus.buf_rdata = (int'(bus.buf_addr) < NBYTES) ? mem[bus.buf_addr] : 8'h00;
        rd_next++;
        rd_cnt++;
        age = 0;
      end else begin
        if (age == 1) bus.buf_rdata = 8'($urandom);
        if (age < 2) age++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic prepare_frame();
    build_expected();
    cap_q.delete();
    byte_idx = 0;
    rd_next  = 0;
    rd_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_req(input bit expect_accept);
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    if (expect_accept) begin
      check("first_start_latency", 32'(bus.spi_start), 32'd1);
      check("busy_after_accept", 32'(frame_busy), 32'd1);
    end
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (byte_idx < target && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_byte%0d", target), 32'(byte_idx >= target), 32'd1);
  endtask

  task automatic wait_done(input bit req_on_done);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("frame_done_in_time(state=%0d)", dbg_state), 32'(frame_done), 32'd1);
    if (req_on_done) frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    check("done_single_pulse", 32'(frame_done), 32'd0);
    check("busy_low_after_done", 32'(frame_busy), 32'd0);
    check("dc_low_after_done", 32'(bus.dc), 32'd0);
    check("bytes_per_frame", 32'(byte_idx), 32'(NTOTAL));
    check("reads_per_frame", 32'(rd_cnt), 32'(NBYTES));
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (req_on_done) begin
      repeat (30) @(negedge clk);
      check("req_at_done_ignored", 32'(frame_busy), 32'd0);
      check("no_bytes_after_done", 32'(byte_idx), 32'(NTOTAL));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({bus.spi_start, bus.spi_data, bus.dc, bus.buf_rd_en,
                     bus.buf_addr, frame_busy, frame_done}), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    vec_t vecs [5];
    int   fg_cnt;

    vecs[0] = '{fill:8'h00, first:8'h00, last:8'h00, dmin:16, dmax:16,
                exp_fg:0,  exp_first:16'h001F, exp_last:16'h001F};
    vecs[1] = '{fill:8'h00, first:8'h01, last:8'h80, dmin:1,  dmax:40,
                exp_fg:2,  exp_first:16'hF800, exp_last:16'hF800};
    vecs[2] = '{fill:8'hAA, first:8'hAA, last:8'hAA, dmin:1,  dmax:40,
                exp_fg:48, exp_first:16'h001F, exp_last:16'hF800};
    vecs[3] = '{fill:8'hFF, first:8'hFE, last:8'h7F, dmin:1,  dmax:4,
                exp_fg:94, exp_first:16'h001F, exp_last:16'h001F};
    vecs[4] = '{fill:8'h55, first:8'h55, last:8'h55, dmin:1,  dmax:3,
                exp_fg:48, exp_first:16'hF800, exp_last:16'h001F};

    reset     = 1'b1;
    init_done = 1'b0;
    frame_req = 1'b0;
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    reset = 1'b0;

    // Request while the panel is not initialised is dropped.
    pulse_req(1'b0);
    repeat (30) @(negedge clk);
    check("no_frame_without_init", 32'(frame_busy), 32'd0);
    check("no_bytes_without_init", 32'(byte_idx), 32'd0);
    init_done = 1'b1;

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      for (int a = 0; a < NBYTES; a++) mem[a] = vecs[i].fill;
      mem[0]          = vecs[i].first;
      mem[NBYTES - 1] = vecs[i].last;
      dmin = vecs[i].dmin;
      dmax = vecs[i].dmax;
      prepare_frame();
      pulse_req(1'b1);
      wait_done(i == 2);
      fg_cnt = 0;
      for (int j = 6; j + 1 < cap_q.size(); j += 2)
        if ({cap_q[j][7:0], cap_q[j + 1][7:0]} == FG) fg_cnt++;
      check($sformatf("v%0d_fg_pixels", i), 32'(fg_cnt), 32'(vecs[i].exp_fg));
      if (cap_q.size() >= NTOTAL) begin
        check($sformatf("v%0d_first_word", i),
              32'({cap_q[6][7:0], cap_q[7][7:0]}), 32'(vecs[i].exp_first));
        check($sformatf("v%0d_last_word", i),
              32'({cap_q[NTOTAL - 2][7:0], cap_q[NTOTAL - 1][7:0]}), 32'(vecs[i].exp_last));
        check($sformatf("v%0d_dc_last_cmd", i), 32'(cap_q[5][8]), 32'd0);
        check($sformatf("v%0d_dc_first_pix", i), 32'(cap_q[6][8]), 32'd1);
      end
    end

    // Mid-frame disturbances: extra requests, init_done dropping, and a
    // buffer write to an already-fetched byte.
    for (int a = 0; a < NBYTES; a++) mem[a] = 8'($urandom);
    dmin = 1;
    dmax = 6;
    prepare_frame();
    pulse_req(1'b1);
    wait_bytes(20);
    pulse_req(1'b0);
    init_done = 1'b0;
    wait_bytes(100);
    mem[0] = ~mem[0];
    pulse_req(1'b0);
    wait_bytes(150);
    init_done = 1'b1;
    wait_done(1'b0);
    repeat (40) @(negedge clk);
    check("single_frame_busy", 32'(frame_busy), 32'd0);
    check("single_frame_bytes", 32'(byte_idx), 32'(NTOTAL));

    // Random buffers and SPI latencies.
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < NBYTES; a++) mem[a] = 8'($urandom);
      dmin = 1;
      dmax = int'($urandom_range(10, 1));
      prepare_frame();
      pulse_req(1'b1);
      wait_done(1'b0);
    end

    // Reset in the middle of the pixel stream, then a clean restart.
    dmin = 1;
    dmax = 5;
    prepare_frame();
    pulse_req(1'b1);
    wait_bytes(100);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_frame_outputs");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < NBYTES; a++) mem[a] = 8'($urandom);
    prepare_frame();
    pulse_req(1'b1);
    wait_done(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
